serial_adder: RTL

//  Bit-serial WIDTH-bit adder. It is the inverse companion to the full_subtract

---
 rtl/serial_adder_pkg.sv | 11 +
 rtl/full_add.sv | 13 +
 rtl/serial_adder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default width and FSM state encoding.
package serial_adder_pkg;

    localparam int SIZE = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

endpackage : serial_adder_pkg

// File: rtl/full_add.sv
// Combinational 1-bit full adder; port order matches the full_subtract cell.
module full_add (
    output logic sum,
    output logic carryOut,
    input  logic a,
    input  logic b,
    input  logic carryIn
);

    assign sum      = a ^ b ^ carryIn;
    assign carryOut = (a & b) | (carryIn & (a ^ b));

endmodule : full_add

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are consumed LSB-first through a single
// full-adder cell, one bit per clock, under a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_r;
    state_e             state_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    // Holds the WIDTH-1 most recent sum bits; the newest bit completes the word.
    logic [WIDTH-2:0]   sum_sh_r;
    logic [WIDTH-1:0]   sum_next_s;
    logic               cy_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               last_s;
    logic               cmsb_in_s;
    logic               fa_sum_s;
    logic               fa_cout_s;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_out_r;
    logic               overflow_r;

    full_add u_full_add (
        .sum      (fa_sum_s),
        .carryOut (fa_cout_s),
        .a        (a_sh_r[0]),
        .b        (b_sh_r[0]),
        .carryIn  (cy_r)
    );

    assign last_s     = (cnt_r == CNT_W'(WIDTH - 1));
    assign sum_next_s = {fa_sum_s, sum_sh_r};
    // On the final bit the carry feeding the adder is the carry into the MSB.
    assign cmsb_in_s  = cy_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_BUSY;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (last_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_BUSY;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath: operand capture, serial add, result and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            sum_sh_r    <= '0;
            cy_r        <= 1'b0;
            cnt_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        cy_r     <= carryIn;
                        sum_sh_r <= '0;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                    end
                end
                S_BUSY: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    sum_sh_r <= sum_next_s[WIDTH-1:1];
                    cy_r     <= fa_cout_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        sum_r       <= sum_next_s;
                        carry_out_r <= fa_cout_s;
                        overflow_r  <= cmsb_in_s ^ fa_cout_s;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign carryOut = carry_out_r;
    assign overflow = overflow_r;

endmodule : serial_adder
